mux_scan_n: RTL and testbench

MUX_SCAN_N -- requirements
Module: mux_scan_n

---
 rtl/mux_scan_n.sv | 133 +++++++++++++
 tb/tb_mux_scan_n.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_n.sv
// mux_scan_n: N-channel registered mux with direct-select and round-robin
// scan modes, and a one-entry valid/ready output stage.
// Ports:
//   clk, rst      rising-edge clock, async active-high reset
//   din  [N*W]    packed channels, channel k at din[k*W +: W]
//   sel  [SW]     channel select used in direct mode
//   mode          0 = direct, 1 = scan
//   en            capture enable
//   mask [N]      channel enables (only with MUX_SCAN_MASK_EN)
//   y    [W]      registered selected sample
//   y_ch [SW]     channel index of the sample in y
//   y_valid       y/y_ch hold an unconsumed sample
//   y_ready       downstream accepts the sample
// Optional feature macro: MUX_SCAN_MASK_EN adds per-channel masking.
module mux_scan_n #(
   parameter int W = 8,
   parameter int N = 8,
   localparam int SW = (N > 2) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N*W-1:0] din,
   input  logic [SW-1:0]  sel,
   input  logic           mode,
   input  logic           en,
`ifdef MUX_SCAN_MASK_EN
   input  logic [N-1:0]   mask,
`endif
   output logic [W-1:0]   y,
   output logic [SW-1:0]  y_ch,
   output logic           y_valid,
   input  logic           y_ready
);

   localparam int SW1 = SW + 1;
   localparam logic [SW:0] N_L = SW1'(N);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t        state_q;
   logic [W-1:0]  y_q;
   logic [SW-1:0] ych_q;
   logic [SW-1:0] ptr_q, ptr_d;
   logic          mode_q;

   logic          take, slot, cap, elig;
   logic [SW-1:0] ptr_eff, tgt, ptr_inc;

`ifdef MUX_SCAN_MASK_EN
   logic          found;
   logic [SW-1:0] tgt_s;
   logic [SW:0]   idx;
`endif

   assign y       = y_q;
   assign y_ch    = ych_q;
   assign y_valid = (state_q == FULL);

   always_comb begin
      take = y_valid & y_ready;
      slot = ~y_valid | take;
      // Entering scan mode restarts the sweep at channel 0.
      ptr_eff = (mode & ~mode_q) ? '0 : ptr_q;
      tgt  = '0;
      elig = 1'b0;
`ifdef MUX_SCAN_MASK_EN
      found = 1'b0;
      tgt_s = '0;
      idx   = '0;
      // First enabled channel at or after ptr_eff, cyclic over N.
      for (int i = 0; i < N; i++) begin
         idx = {1'b0, ptr_eff} + SW1'(i);
         if (idx >= N_L) idx = idx - N_L;
         if (!found && mask[idx[SW-1:0]]) begin
            found = 1'b1;
            tgt_s = idx[SW-1:0];
         end
      end
      if (mode) begin
         tgt  = tgt_s;
         elig = found;
      end else begin
         tgt  = sel;
         elig = ({1'b0, sel} < N_L) && mask[sel];
      end
`else
      if (mode) begin
         tgt  = ptr_eff;
         elig = 1'b1;
      end else begin
         tgt  = sel;
         elig = ({1'b0, sel} < N_L);
      end
`endif
      cap = en & slot & elig;
      // Wrap at N-1, not at 2^SW-1.
      ptr_inc = ({1'b0, tgt} == N_L - SW1'(1)) ? '0 : tgt + SW'(1);
      ptr_d = ptr_q;
      if (mode) ptr_d = cap ? ptr_inc : ptr_eff;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         y_q     <= '0;
         ych_q   <= '0;
         ptr_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         mode_q <= mode;
         ptr_q  <= ptr_d;
         unique case (state_q)
            EMPTY: begin
               if (cap) begin
                  y_q     <= din[tgt*W +: W];
                  ych_q   <= tgt;
                  state_q <= FULL;
               end
            end
            FULL: begin
               if (cap) begin
                  y_q   <= din[tgt*W +: W];
                  ych_q <= tgt;
               end else if (y_ready) begin
                  state_q <= EMPTY;
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_scan_n.sv
// tb_mux_scan_n: checks two mux_scan_n instances (N=8 and N=5, W=8)
// against a behavioural model under directed and random stimulus.
module tb_mux_scan_n;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  sel;
   logic        mode, en, rdy;
   logic [63:0] dinA;
   logic [39:0] dinB;
   logic [7:0]  yA, yB;
   logic [2:0]  chA, chB;
   logic        vA, vB;
`ifdef MUX_SCAN_MASK_EN
   logic [7:0]  mA;
   logic [4:0]  mB;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   int NS[2] = '{8, 5};
   logic [7:0] ch[2][8];
   int mv[2], my[2], mch[2], mptr[2], mmp[2], mk[2];

   always #5 clk = ~clk;

   mux_scan_n #(.W(8), .N(8)) u_a (
      .clk(clk), .rst(rst), .din(dinA), .sel(sel),
      .mode(mode), .en(en),
`ifdef MUX_SCAN_MASK_EN
      .mask(mA),
`endif
      .y(yA), .y_ch(chA), .y_valid(vA), .y_ready(rdy)
   );

   mux_scan_n #(.W(8), .N(5)) u_b (
      .clk(clk), .rst(rst), .din(dinB), .sel(sel),
      .mode(mode), .en(en),
`ifdef MUX_SCAN_MASK_EN
      .mask(mB),
`endif
      .y(yB), .y_ch(chB), .y_valid(vB), .y_ready(rdy)
   );

   task automatic pack();
      for (int k = 0; k < 8; k++) dinA[k*8 +: 8] = ch[0][k];
      for (int k = 0; k < 5; k++) dinB[k*8 +: 8] = ch[1][k];
   endtask

   task automatic setmask(int a, int b);
      mk[0] = a;
      mk[1] = b;
`ifdef MUX_SCAN_MASK_EN
      mA = 8'(a);
      mB = 5'(b);
`endif
   endtask

   task automatic mreset();
      for (int k = 0; k < 2; k++) begin
         mv[k] = 0; my[k] = 0; mch[k] = 0; mptr[k] = 0; mmp[k] = 0;
      end
   endtask

   // One clock edge of the reference behaviour for instance k.
   task automatic model(int k);
      int n, take, slot, pe, tgt, el, cap;
      n    = NS[k];
      take = (mv[k] != 0) && rdy;
      slot = (mv[k] == 0) || take;
      pe   = (mode && mmp[k] == 0) ? 0 : mptr[k];
      el   = 0;
      tgt  = 0;
      if (!mode) begin
         tgt = int'(sel);
         if (tgt < n && mk[k][tgt]) el = 1;
      end else begin
         for (int i = 0; i < n; i++) begin
            int c;
            c = (pe + i) % n;
            if (el == 0 && mk[k][c]) begin
               el  = 1;
               tgt = c;
            end
         end
      end
      cap = (en && slot && el) ? 1 : 0;
      if (cap) begin
         my[k]  = ch[k][tgt];
         mch[k] = tgt;
         mv[k]  = 1;
      end else if (take) begin
         mv[k] = 0;
      end
      if (mode) mptr[k] = cap ? (tgt + 1) % n : pe;
      mmp[k] = mode;
   endtask

   task automatic chk(string tag);
      n_assert++;
      assert (yA === 8'(my[0])) else begin
         n_fail++; $error("FAIL %s A.y got %h exp %h", tag, yA, my[0]);
      end
      n_assert++;
      assert (chA === 3'(mch[0])) else begin
         n_fail++; $error("FAIL %s A.y_ch got %0d exp %0d", tag, chA, mch[0]);
      end
      n_assert++;
      assert (vA === 1'(mv[0])) else begin
         n_fail++; $error("FAIL %s A.y_valid got %b exp %0d", tag, vA, mv[0]);
      end
      n_assert++;
      assert (yB === 8'(my[1])) else begin
         n_fail++; $error("FAIL %s B.y got %h exp %h", tag, yB, my[1]);
      end
      n_assert++;
      assert (chB === 3'(mch[1])) else begin
         n_fail++; $error("FAIL %s B.y_ch got %0d exp %0d", tag, chB, mch[1]);
      end
      n_assert++;
      assert (vB === 1'(mv[1])) else begin
         n_fail++; $error("FAIL %s B.y_valid got %b exp %0d", tag, vB, mv[1]);
      end
   endtask

   task automatic cyc(string tag);
      model(0);
      model(1);
      @(posedge clk);
      #1;
      chk(tag);
   endtask

   initial begin
      int seq[7];
      int seqm[4];
      seq  = '{0, 1, 2, 3, 4, 0, 1};
      seqm = '{2, 5, 7, 2};
      sel = '0; mode = 1'b0; en = 1'b0; rdy = 1'b0;
      for (int k = 0; k < 8; k++) begin
         ch[0][k] = 8'h10 + 8'(k);
         ch[1][k] = 8'h10 + 8'(k);
      end
      pack();
      setmask(8'hFF, 5'h1F);
      mreset();
      #12;
      chk("reset");
      rst = 1'b0;

      // Direct select: A takes channel 5, B sees sel 5 as out of range.
      sel = 3'd5; en = 1'b1; rdy = 1'b1;
      cyc("direct");
      n_assert++;
      assert (yA === 8'h15 && chA === 3'd5 && vA === 1'b1) else begin
         n_fail++; $error("FAIL direct_A got y=%h ch=%0d v=%b exp 15/5/1", yA, chA, vA);
      end
      n_assert++;
      assert (vB === 1'b0) else begin
         n_fail++; $error("FAIL direct_B_illegal got v=%b exp 0", vB);
      end

      sel = 3'd7;
      cyc("illegal");
      n_assert++;
      assert (vB === 1'b0) else begin
         n_fail++; $error("FAIL illegal_sel7 got v=%b exp 0", vB);
      end

      // Scan wrap on N=5.
      mode = 1'b1;
      for (int i = 0; i < 7; i++) begin
         cyc("scan");
         n_assert++;
         assert (chB === 3'(seq[i]) && vB === 1'b1) else begin
            n_fail++; $error("FAIL scan_wrap[%0d] got ch=%0d v=%b exp %0d", i, chB, vB, seq[i]);
         end
      end

      // Backpressure in direct mode.
      mode = 1'b0; sel = 3'd3;
      cyc("bp_load");
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 8; k++) begin
            ch[0][k] = 8'($urandom);
            ch[1][k] = 8'($urandom);
         end
         pack();
         sel = 3'($urandom);
         cyc("bp_hold");
         n_assert++;
         assert (yA === 8'h13 && chA === 3'd3 && vA === 1'b1) else begin
            n_fail++; $error("FAIL bp_hold got y=%h ch=%0d exp 13/3", yA, chA);
         end
      end

      // Backpressure in scan mode freezes the pointer.
      rdy = 1'b1; mode = 1'b1;
      cyc("sbp_load");
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) cyc("sbp_hold");
      rdy = 1'b1;
      cyc("sbp_resume");
      n_assert++;
      assert (chA === 3'd1) else begin
         n_fail++; $error("FAIL scan_ptr_frozen got ch=%0d exp 1", chA);
      end

      // Asynchronous reset mid-scan.
      for (int i = 0; i < 10 && chB !== 3'd3; i++) cyc("pre_rst");
      n_assert++;
      assert (chB === 3'd3) else begin
         n_fail++; $error("FAIL reach_ch3 got ch=%0d exp 3", chB);
      end
      #2 rst = 1'b1;
      #1;
      mreset();
      chk("rst_async");
      #2 rst = 1'b0;
      cyc("post_rst");
      n_assert++;
      assert (chB === 3'd0 && vB === 1'b1 && chA === 3'd0) else begin
         n_fail++; $error("FAIL post_rst got chB=%0d v=%b exp 0/1", chB, vB);
      end

`ifdef MUX_SCAN_MASK_EN
      mode = 1'b0;
      cyc("mask_pre");
      setmask(8'b1010_0100, 5'b10010);
      mode = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc("mask_scan");
         n_assert++;
         assert (chA === 3'(seqm[i])) else begin
            n_fail++; $error("FAIL mask_seq[%0d] got %0d exp %0d", i, chA, seqm[i]);
         end
      end
      setmask(0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc("mask_zero");
         n_assert++;
         assert (vA === 1'b0) else begin
            n_fail++; $error("FAIL mask_zero got v=%b exp 0", vA);
         end
      end
      setmask(8'hFF, 5'h1F);
`endif

      // Random traffic.
      for (int t = 0; t < 400; t++) begin
         for (int k = 0; k < 8; k++) begin
            ch[0][k] = 8'($urandom);
            ch[1][k] = 8'($urandom);
         end
         pack();
         sel  = 3'($urandom);
         if ($urandom_range(7) == 0) mode = ~mode;
         en   = ($urandom_range(3) != 0);
         rdy  = ($urandom_range(2) != 0);
`ifdef MUX_SCAN_MASK_EN
         if ($urandom_range(15) == 0)
            setmask(int'($urandom_range(255)), int'($urandom_range(31)));
`endif
         cyc("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
